// File: rtl/microwave_control.sv
// Magnetron control FSM: button edge detection, door interlock and cook/pause/done sequencing.
// Optional build macro CONTROL_SYNC_EN adds 2-flop synchronizers on all four control inputs.
module microwave_control (
    input  logic clk,
    input  logic clrn,
    input  logic startn,
    input  logic stopn,
    input  logic door_closed,
    input  logic timer_done,
    output logic mag_on,
    output logic paused,
    output logic done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic start_c, stop_c, door_c, timer_c;
    logic start_hist, stop_hist;
    logic start_ev, stop_ev, start_qual;

`ifdef CONTROL_SYNC_EN
    logic [1:0] start_sync, stop_sync, door_sync, timer_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            start_sync <= 2'b11;
            stop_sync  <= 2'b11;
            door_sync  <= 2'b11;
            timer_sync <= 2'b11;
        end else begin
            start_sync <= {start_sync[0], startn};
            stop_sync  <= {stop_sync[0], stopn};
            door_sync  <= {door_sync[0], door_closed};
            timer_sync <= {timer_sync[0], timer_done};
        end
    end

    assign start_c = start_sync[1];
    assign stop_c  = stop_sync[1];
    assign door_c  = door_sync[1];
    assign timer_c = timer_sync[1];
`else
    assign start_c = startn;
    assign stop_c  = stopn;
    assign door_c  = door_closed;
    assign timer_c = timer_done;
`endif

    // History flops reset high so a button held through reset still gives one event.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            start_hist <= 1'b1;
            stop_hist  <= 1'b1;
        end else begin
            start_hist <= start_c;
            stop_hist  <= stop_c;
        end
    end

    assign start_ev   = start_hist & ~start_c;
    assign stop_ev    = stop_hist & ~stop_c;
    // A simultaneous stop suppresses start everywhere.
    assign start_qual = start_ev & ~stop_ev & door_c & ~timer_c;

    always_comb begin
        // NOTE: default assignment first keeps this block free of inferred latches.
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start_qual) state_next = COOK;
            end
            COOK: begin
                if (timer_c)                 state_next = DONE;
                else if (stop_ev || !door_c) state_next = PAUSE;
            end
            PAUSE: begin
                if (stop_ev)         state_next = IDLE;
                else if (timer_c)    state_next = IDLE;
                else if (start_qual) state_next = COOK;
            end
            DONE: begin
                if (start_ev || stop_ev || !door_c) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state  <= IDLE;
            paused <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            paused <= (state_next == PAUSE);
            done   <= (state_next == DONE);
        end
    end

    // Raw door switch gates the magnetron so opening the door cuts power before the FSM reacts.
    assign mag_on = (state == COOK) & door_closed;

endmodule

// File: tb/tb_microwave_control.sv
// Self-checking bench for microwave_control: table of level vectors plus hand-written
// sequences for startup, immediate door cut-off and asynchronous reset.
module tb_microwave_control;

`ifdef CONTROL_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic clrn;
    logic startn, stopn, door_closed, timer_done;
    logic mag_on, paused, done;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic       startn;
        logic       stopn;
        logic       door;
        logic       timer;
        logic [2:0] exp;   // {mag_on, paused, done}
    } vec_t;

    vec_t vecs [36];

    microwave_control dut (
        .clk        (clk),
        .clrn       (clrn),
        .startn     (startn),
        .stopn      (stopn),
        .door_closed(door_closed),
        .timer_done (timer_done),
        .mag_on     (mag_on),
        .paused     (paused),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {mag_on,paused,done}=%b expected %b", name, act, exp);
        end
    endtask

    // Hold current inputs long enough for the FSM to react, then sample away from the edge.
    task automatic step();
        repeat (LAT + 1) @(posedge clk);
        #1;
    endtask

    initial begin
        //            st    sp    door  timer exp
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b100};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b010};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b010};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b000};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b000};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b100};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b100};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b010};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b010};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b010};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b100};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b100};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b001};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b000};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b000};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b000};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b000};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b000};
        vecs[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b000};
        vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b100};
        vecs[20] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b100};
        vecs[21] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b010};
        vecs[22] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b010};
        vecs[23] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b000};
        vecs[24] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b000};
        vecs[25] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b100};
        vecs[26] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b100};
        vecs[27] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b010};
        vecs[28] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b010};
        vecs[29] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b000};
        vecs[30] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b000};
        vecs[31] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b100};
        vecs[32] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b100};
        vecs[33] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b001};
        vecs[34] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b000};
        vecs[35] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b000};

        // Startup with start already held low through reset.
        clrn = 1'b0; startn = 1'b0; stopn = 1'b1; door_closed = 1'b1; timer_done = 1'b0;
        #1;
        check("reset_state", {mag_on, paused, done}, 3'b000);
        @(posedge clk); @(posedge clk); #3;
        clrn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("startup_start", {mag_on, paused, done}, 3'b100);
        repeat (4) @(posedge clk);
        #1;
        check("held_start", {mag_on, paused, done}, 3'b100);

        for (int i = 0; i < 36; i++) begin
            startn      = vecs[i].startn;
            stopn       = vecs[i].stopn;
            door_closed = vecs[i].door;
            timer_done  = vecs[i].timer;
            step();
            check($sformatf("vec%0d", i), {mag_on, paused, done}, vecs[i].exp);
        end

        // Door opening cuts the magnetron before any clock edge.
        startn = 1'b0; step();
        check("door_pre_cook", {mag_on, paused, done}, 3'b100);
        startn = 1'b1; step();
        door_closed = 1'b0;
        #1;
        check("door_immediate", {mag_on, 2'b00}, 3'b000);
        step();
        check("door_paused", {mag_on, paused, done}, 3'b010);

        // Resume, then asynchronous reset between edges.
        door_closed = 1'b1; startn = 1'b0; step();
        check("resume_cook", {mag_on, paused, done}, 3'b100);
        startn = 1'b1; step();
        @(posedge clk); #3;
        clrn = 1'b0;
        #1;
        check("async_reset", {mag_on, paused, done}, 3'b000);
        #3;
        clrn = 1'b1;
        step(); step();
        check("idle_after_reset", {mag_on, paused, done}, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
